// File: rtl/mem_dump_engine.sv
// rtl/mem_dump_engine.sv - end-of-program DMEM readout engine for the pipelined DLX core
//
// Purpose: watches the fetched instruction stream for TRAP_WORD. On the trap it
//   freezes the core and reads WORD_COUNT big-endian words from byte-wide DMEM,
//   starting at START_ADDR. Each word is streamed out on a valid/ready port, and
//   the engine then parks in DONE with the core still frozen until reset.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   instruction, instr_valid - instruction currently fetched by the IFU
//   freeze                  - pipeline stall, held from trap until reset
//   mem_rd, mem_addr        - DMEM byte read strobe and byte address
//   mem_rdata               - DMEM byte, valid the cycle after mem_rd
//   out_valid, out_ready    - word stream handshake
//   out_addr, out_data      - byte address and big-endian data of the emitted word
//   busy, done              - busy in READ/EMIT, done in DONE
// Option: define MEM_DUMP_CHECKSUM_EN to append one extra beat after the data.
//   That beat has out_addr=32'hFFFFFFFC and carries the mod-2^32 sum of all data words.
module mem_dump_engine #(
    parameter logic [31:0] START_ADDR = 32'd8192,
    parameter int unsigned WORD_COUNT = 10,
    parameter logic [31:0] TRAP_WORD  = 32'h44000300
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:31] instruction,
    input  logic        instr_valid,
    output logic        freeze,
    output logic        mem_rd,
    output logic [0:31] mem_addr,
    input  logic [0:7]  mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:31] out_addr,
    output logic [0:31] out_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, READ, EMIT, DONE} state_t;

    localparam logic [31:0] LAST_CNT = 32'(WORD_COUNT);

    state_t      state;
    logic [2:0]  bidx;       // READ sub-cycle 0..4
    logic [31:0] word_addr;
    logic [31:0] word_cnt;   // words already accepted

    logic        trap;
    logic [31:0] next_cnt;
    logic [31:0] next_addr;
    logic        last_word;

    assign trap      = instr_valid && (instruction == TRAP_WORD);
    assign next_cnt  = word_cnt + 32'd1;
    assign next_addr = word_addr + 32'd4;
    assign last_word = (next_cnt == LAST_CNT);

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [31:0] sum;
    logic        csum_beat;  // the beat in EMIT is the checksum, not a data word
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bidx      <= 3'd0;
            word_addr <= 32'd0;
            word_cnt  <= 32'd0;
            freeze    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= 32'd0;
            out_valid <= 1'b0;
            out_addr  <= 32'd0;
            out_data  <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum       <= 32'd0;
            csum_beat <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (trap) begin
                        freeze    <= 1'b1;
                        word_addr <= START_ADDR;
                        word_cnt  <= 32'd0;
                        bidx      <= 3'd0;
                        if (LAST_CNT == 32'd0) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                            // Empty window: only the checksum beat (value 0) is sent.
                            state     <= EMIT;
                            busy      <= 1'b1;
                            out_valid <= 1'b1;
                            out_addr  <= 32'hFFFF_FFFC;
                            out_data  <= 32'd0;
                            csum_beat <= 1'b1;
`else
                            state     <= DONE;
                            done      <= 1'b1;
`endif
                        end else begin
                            state    <= READ;
                            busy     <= 1'b1;
                            mem_rd   <= 1'b1;
                            mem_addr <= START_ADDR;
                        end
                    end
                end

                READ: begin
                    // Byte requested in sub-cycle b-1 arrives in sub-cycle b; bit 0 is the MSB.
                    case (bidx)
                        3'd1:    out_data[0:7]   <= mem_rdata;
                        3'd2:    out_data[8:15]  <= mem_rdata;
                        3'd3:    out_data[16:23] <= mem_rdata;
                        3'd4:    out_data[24:31] <= mem_rdata;
                        default: ;
                    endcase
                    if (bidx == 3'd4) begin
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        out_addr  <= word_addr;
                    end else begin
                        bidx <= bidx + 3'd1;
                        if (bidx == 3'd3) begin
                            mem_rd <= 1'b0;
                        end else begin
                            mem_rd   <= 1'b1;
                            mem_addr <= mem_addr + 32'd1;
                        end
                    end
                end

                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
                        if (csum_beat) begin
                            csum_beat <= 1'b0;
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            sum       <= sum + out_data;
                            word_cnt  <= next_cnt;
                            word_addr <= next_addr;
                            if (last_word) begin
                                // Stay in EMIT for the checksum beat, including this word.
                                out_valid <= 1'b1;
                                out_addr  <= 32'hFFFF_FFFC;
                                out_data  <= sum + out_data;
                                csum_beat <= 1'b1;
                            end else begin
                                state    <= READ;
                                bidx     <= 3'd0;
                                mem_rd   <= 1'b1;
                                mem_addr <= next_addr;
                            end
                        end
`else
                        word_cnt  <= next_cnt;
                        word_addr <= next_addr;
                        if (last_word) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= READ;
                            bidx     <= 3'd0;
                            mem_rd   <= 1'b1;
                            mem_addr <= next_addr;
                        end
`endif
                    end
                end

                DONE: ;  // sticky until reset, core stays frozen

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_engine.sv
// tb/tb_mem_dump_engine.sv - self-checking bench for mem_dump_engine
`timescale 1ns/1ps
module tb_mem_dump_engine;

    localparam logic [31:0] TRAP = 32'h4400_0300;
    localparam logic [31:0] BASE = 32'd8192;
    localparam int          WC   = 10;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- DUT a: WORD_COUNT=10 ----------------
    logic        a_reset, a_iv, a_rdy, a_freeze, a_mem_rd, a_ov, a_busy, a_done;
    logic [31:0] a_instr, a_mem_addr, a_oaddr, a_odata;
    logic [7:0]  a_rdata;
    logic [7:0]  dmem_a [0:63];

    mem_dump_engine #(.START_ADDR(BASE), .WORD_COUNT(WC), .TRAP_WORD(TRAP)) dut_a (
        .clock(clock), .reset(a_reset), .instruction(a_instr), .instr_valid(a_iv),
        .freeze(a_freeze), .mem_rd(a_mem_rd), .mem_addr(a_mem_addr), .mem_rdata(a_rdata),
        .out_valid(a_ov), .out_ready(a_rdy), .out_addr(a_oaddr), .out_data(a_odata),
        .busy(a_busy), .done(a_done));

    function automatic logic [7:0] rd_a(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (off < 32'd64) return dmem_a[off[5:0]];
        return 8'hEE;
    endfunction

    always @(posedge clock) if (a_mem_rd) a_rdata <= rd_a(a_mem_addr);

    // ---------------- DUT b: WORD_COUNT=1, DMEM 01 02 03 04 ----------------
    logic        b_reset, b_iv, b_rdy, b_freeze, b_mem_rd, b_ov, b_busy, b_done;
    logic [31:0] b_instr, b_mem_addr, b_oaddr, b_odata;
    logic [7:0]  b_rdata;

    mem_dump_engine #(.START_ADDR(BASE), .WORD_COUNT(1), .TRAP_WORD(TRAP)) dut_b (
        .clock(clock), .reset(b_reset), .instruction(b_instr), .instr_valid(b_iv),
        .freeze(b_freeze), .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_rdata(b_rdata),
        .out_valid(b_ov), .out_ready(b_rdy), .out_addr(b_oaddr), .out_data(b_odata),
        .busy(b_busy), .done(b_done));

    always @(posedge clock)
        if (b_mem_rd) b_rdata <= ((b_mem_addr - BASE) < 32'd4) ? 8'(b_mem_addr - BASE + 32'd1) : 8'h00;

    // ---------------- DUT z: WORD_COUNT=0 ----------------
    logic        z_reset, z_iv, z_rdy, z_freeze, z_mem_rd, z_ov, z_busy, z_done;
    logic [31:0] z_instr, z_mem_addr, z_oaddr, z_odata;
    logic [7:0]  z_rdata;
    assign z_rdata = 8'h00;

    mem_dump_engine #(.START_ADDR(BASE), .WORD_COUNT(0), .TRAP_WORD(TRAP)) dut_z (
        .clock(clock), .reset(z_reset), .instruction(z_instr), .instr_valid(z_iv),
        .freeze(z_freeze), .mem_rd(z_mem_rd), .mem_addr(z_mem_addr), .mem_rdata(z_rdata),
        .out_valid(z_ov), .out_ready(z_rdy), .out_addr(z_oaddr), .out_data(z_odata),
        .busy(z_busy), .done(z_done));

    // ---------------- cycle table for DUT b ----------------
    typedef struct {
        logic [31:0] instr;
        logic        iv;
        logic        rdy;
        logic        freeze, busy, done, mem_rd;
        logic        chk_addr;
        logic [31:0] mem_addr;
        logic        ov;
        logic [31:0] oaddr, odata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [31:0] instr, input logic iv, input logic rdy,
                                input logic fr, input logic bs, input logic dn, input logic rd,
                                input logic ca, input logic [31:0] ma, input logic ov,
                                input logic [31:0] oa, input logic [31:0] od);
        vec_t v;
        v.instr = instr; v.iv = iv; v.rdy = rdy;
        v.freeze = fr; v.busy = bs; v.done = dn; v.mem_rd = rd;
        v.chk_addr = ca; v.mem_addr = ma; v.ov = ov; v.oaddr = oa; v.odata = od;
        return v;
    endfunction

    task automatic reset_a();
        a_reset = 1'b1; a_instr = 32'd0; a_iv = 1'b0; a_rdy = 1'b0;
        @(posedge clock); #1;
        a_reset = 1'b0;
    endtask

    task automatic check_a_idle(input string tag);
        check({tag, " freeze"},    32'(a_freeze), 32'd0);
        check({tag, " busy"},      32'(a_busy),   32'd0);
        check({tag, " done"},      32'(a_done),   32'd0);
        check({tag, " mem_rd"},    32'(a_mem_rd), 32'd0);
        check({tag, " out_valid"}, 32'(a_ov),     32'd0);
        check({tag, " mem_addr"},  a_mem_addr,    32'd0);
        check({tag, " out_addr"},  a_oaddr,       32'd0);
        check({tag, " out_data"},  a_odata,       32'd0);
    endtask

    // mode 0: ready always high; 1: first EMIT held 7 cycles with a trap driven; 2: random ready
    // abort_after>0: return one cycle into READ after that many beats were accepted
    task automatic run_dump(input int mode, input int abort_after, input string tag);
        logic [31:0] eq_addr[$];
        logic [31:0] eq_data[$];
        logic [31:0] sum, w, prev_data, prev_addr;
        int          accepted, last_acc, cyc, held, exp_beats;
        logic        prev_pending;
        sum = 32'd0; accepted = 0; last_acc = 0; cyc = 0; held = 0; prev_pending = 1'b0;
        prev_data = 32'd0; prev_addr = 32'd0;
        for (int k = 0; k < WC; k++) begin
            w = {dmem_a[4*k], dmem_a[4*k+1], dmem_a[4*k+2], dmem_a[4*k+3]};
            eq_addr.push_back(BASE + 32'(4*k));
            eq_data.push_back(w);
            sum = sum + w;
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        eq_addr.push_back(32'hFFFF_FFFC);
        eq_data.push_back(sum);
`endif
        exp_beats = eq_addr.size();

        a_instr = TRAP; a_iv = 1'b1; a_rdy = 1'b1;
        @(posedge clock); #1;
        a_instr = 32'd0; a_iv = 1'b0;

        while (!a_done && cyc < 2000) begin
            if (mode == 0) begin
                a_rdy = 1'b1;
            end else if (mode == 1) begin
                if (a_ov && accepted == 0 && held < 7) begin
                    a_rdy = 1'b0; a_instr = TRAP; a_iv = 1'b1; held++;
                    check({tag, " held out_valid"}, 32'(a_ov), 32'd1);
                    check({tag, " held out_data"}, a_odata, eq_data[0]);
                end else begin
                    a_rdy = 1'b1; a_instr = 32'd0; a_iv = 1'b0;
                end
            end else begin
                a_rdy = 1'($urandom_range(0, 1));
            end

            if (prev_pending) begin
                check({tag, " hold valid"}, 32'(a_ov), 32'd1);
                check({tag, " hold data"},  a_odata, prev_data);
                check({tag, " hold addr"},  a_oaddr, prev_addr);
            end
            if (a_ov) check({tag, " no read while emitting"}, 32'(a_mem_rd), 32'd0);

            if (a_ov && a_rdy) begin
                if (eq_addr.size() > 0) begin
                    check($sformatf("%s beat%0d addr", tag, accepted), a_oaddr, eq_addr.pop_front());
                    check($sformatf("%s beat%0d data", tag, accepted), a_odata, eq_data.pop_front());
                end
                if (mode == 0 && accepted > 0 && accepted < WC)
                    check($sformatf("%s beat%0d spacing", tag, accepted), 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                accepted++;
            end
            prev_pending = a_ov && !a_rdy;
            prev_data = a_odata;
            prev_addr = a_oaddr;

            @(posedge clock); #1;
            cyc++;
            if (abort_after > 0 && accepted == abort_after) begin
                @(posedge clock); #1;
                a_rdy = 1'b0;
                return;
            end
        end
        a_instr = 32'd0; a_iv = 1'b0;
        check({tag, " done reached"}, 32'(a_done),   32'd1);
        check({tag, " beat count"},   32'(accepted), 32'(exp_beats));
        check({tag, " busy in done"}, 32'(a_busy),   32'd0);
        check({tag, " freeze in done"}, 32'(a_freeze), 32'd1);
        repeat (3) @(posedge clock);
        #1;
        check({tag, " done sticky"},  32'(a_done),   32'd1);
        check({tag, " no valid in done"}, 32'(a_ov), 32'd0);
        a_rdy = 1'b0;
    endtask

    initial begin
        a_reset = 1'b1; b_reset = 1'b1; z_reset = 1'b1;
        a_instr = 32'd0; b_instr = 32'd0; z_instr = 32'd0;
        a_iv = 1'b0; b_iv = 1'b0; z_iv = 1'b0;
        a_rdy = 1'b0; b_rdy = 1'b0; z_rdy = 1'b1;
        for (int i = 0; i < 64; i++) dmem_a[i] = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check_a_idle("reset");
        a_reset = 1'b0; b_reset = 1'b0; z_reset = 1'b0;

        // ---- DUT b: cycle-exact single-word dump ----
        tbl.push_back(mk(32'h4400_0301, 1, 1, 0, 0, 0, 0, 1, 32'd0,   0, 0, 0));
        tbl.push_back(mk(TRAP,          0, 1, 0, 0, 0, 0, 1, 32'd0,   0, 0, 0));
        tbl.push_back(mk(TRAP,          1, 1, 1, 1, 0, 1, 1, BASE,    0, 0, 0));
        tbl.push_back(mk(32'd0,         0, 1, 1, 1, 0, 1, 1, BASE+1,  0, 0, 0));
        tbl.push_back(mk(32'd0,         0, 1, 1, 1, 0, 1, 1, BASE+2,  0, 0, 0));
        tbl.push_back(mk(32'd0,         0, 1, 1, 1, 0, 1, 1, BASE+3,  0, 0, 0));
        tbl.push_back(mk(32'd0,         0, 1, 1, 1, 0, 0, 0, 32'd0,   0, 0, 0));
        tbl.push_back(mk(32'd0,         0, 1, 1, 1, 0, 0, 0, 32'd0,   1, BASE, 32'h0102_0304));
`ifdef MEM_DUMP_CHECKSUM_EN
        tbl.push_back(mk(32'd0,         0, 1, 1, 1, 0, 0, 0, 32'd0,   1, 32'hFFFF_FFFC, 32'h0102_0304));
`else
        tbl.push_back(mk(32'd0,         0, 1, 1, 0, 1, 0, 0, 32'd0,   0, 0, 0));
`endif
        tbl.push_back(mk(TRAP,          1, 1, 1, 0, 1, 0, 0, 32'd0,   0, 0, 0));
        tbl.push_back(mk(32'd0,         0, 1, 1, 0, 1, 0, 0, 32'd0,   0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            b_instr = tbl[i].instr; b_iv = tbl[i].iv; b_rdy = tbl[i].rdy;
            @(posedge clock); #1;
            check($sformatf("tbl[%0d] freeze", i), 32'(b_freeze), 32'(tbl[i].freeze));
            check($sformatf("tbl[%0d] busy", i),   32'(b_busy),   32'(tbl[i].busy));
            check($sformatf("tbl[%0d] done", i),   32'(b_done),   32'(tbl[i].done));
            check($sformatf("tbl[%0d] mem_rd", i), 32'(b_mem_rd), 32'(tbl[i].mem_rd));
            if (tbl[i].chk_addr) check($sformatf("tbl[%0d] mem_addr", i), b_mem_addr, tbl[i].mem_addr);
            check($sformatf("tbl[%0d] out_valid", i), 32'(b_ov), 32'(tbl[i].ov));
            if (tbl[i].ov) begin
                check($sformatf("tbl[%0d] out_addr", i), b_oaddr, tbl[i].oaddr);
                check($sformatf("tbl[%0d] out_data", i), b_odata, tbl[i].odata);
            end
        end
        b_instr = 32'd0; b_iv = 1'b0;

        // ---- DUT z: empty window ----
        z_instr = TRAP; z_iv = 1'b1;
        @(posedge clock); #1;
        z_instr = 32'd0; z_iv = 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
        check("wc0 csum valid", 32'(z_ov),   32'd1);
        check("wc0 csum addr",  z_oaddr,     32'hFFFF_FFFC);
        check("wc0 csum data",  z_odata,     32'd0);
        check("wc0 csum busy",  32'(z_busy), 32'd1);
        check("wc0 csum mem_rd", 32'(z_mem_rd), 32'd0);
        @(posedge clock); #1;
`endif
        check("wc0 done",   32'(z_done),   32'd1);
        check("wc0 freeze", 32'(z_freeze), 32'd1);
        check("wc0 busy",   32'(z_busy),   32'd0);
        for (int i = 0; i < 4; i++) begin
            check("wc0 no mem_rd",    32'(z_mem_rd), 32'd0);
            check("wc0 no out_valid", 32'(z_ov),     32'd0);
            @(posedge clock); #1;
        end

        // ---- DUT a: words 1..10 ----
        for (int k = 0; k < WC; k++) begin
            dmem_a[4*k] = 8'h00; dmem_a[4*k+1] = 8'h00; dmem_a[4*k+2] = 8'h00;
            dmem_a[4*k+3] = 8'(k + 1);
        end
        run_dump(0, 0, "stream");
        reset_a();
        check_a_idle("after done reset");
        run_dump(1, 0, "backpressure");

        // reset in the READ of the third word, then restart from the start address
        reset_a();
        run_dump(0, 2, "abort");
        check("abort mid-read", 32'(a_mem_rd), 32'd1);
        a_reset = 1'b1;
        @(posedge clock); #1;
        a_reset = 1'b0;
        check_a_idle("abort reset");
        run_dump(0, 0, "restart");

        // random DMEM contents with random backpressure
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 64; i++) dmem_a[i] = 8'($urandom);
            reset_a();
            run_dump(2, 0, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_dump_engine.md
Name: mem_dump_engine

Overview:
- Hardware end-of-program memory readout unit for the pipelined DLX core.
- Watches the fetched instruction stream for the end-of-program trap (0x44000300).
- On the trap, freezes the core, reads a window of byte-wide DMEM as big-endian 32-bit words, and streams each word out over a valid/ready port.
- Sits beside the memory stage on the DMEM read side; complements the load path that fills IMEM/DMEM.

Parameters:
- START_ADDR, 32'd8192, byte address of first word dumped (must be 4-aligned).
- WORD_COUNT, 10, number of 32-bit words dumped (0 allowed).
- TRAP_WORD, 32'h44000300, instruction encoding that triggers the dump.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- instruction  input  [0:31]  instruction currently fetched by IFU.
- instr_valid  input  1  instruction is valid this cycle.
- freeze  output  1  stalls the pipeline while the dump runs.
- mem_rd  output  1  DMEM byte read strobe.
- mem_addr  output  [0:31]  DMEM byte address.
- mem_rdata  input  [0:7]  DMEM byte; valid the cycle after mem_rd.
- out_valid  output  1  out_addr/out_data valid.
- out_ready  input  1  consumer accepts the word this cycle.
- out_addr  output  [0:31]  byte address of the emitted word.
- out_data  output  [0:31]  word assembled as {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
- busy  output  1  high in any state except IDLE and DONE.
- done  output  1  high in DONE.

Behaviour:
- Reset values: state=IDLE, and freeze, mem_rd, out_valid, busy, done all 0. mem_addr, out_addr and out_data are 0; the word counter and byte index are 0.
- IDLE:
  - instr_valid && instruction==TRAP_WORD: next cycle enters READ, freeze=1, busy=1, word address=START_ADDR, byte index=0.
  - Triggers in any other state are ignored.
- READ:
  - Cycles 0..3: mem_rd=1, mem_addr=word_addr+b, for b=0..3.
  - The byte from cycle b is captured on the following edge into out_data bits [8b:8b+7]; bit 0 is the MSB.
  - Cycle 4: mem_rd=0, last byte captured; then enter EMIT.
  - Five cycles per word; mem_rd is never asserted outside READ.
- EMIT:
  - out_valid=1, out_addr=word_addr.
  - out_data and out_addr are held stable until out_valid && out_ready.
  - On handshake:
    - counter+1 and word_addr+4; 32-bit wrap modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
    - If counter reaches WORD_COUNT, enter DONE; otherwise return to READ at byte index 0.
  - out_ready asserted before out_valid has no effect.
- DONE:
  - done=1, freeze=1, busy=0, out_valid=0.
  - Sticky until reset; the core stays halted.
- WORD_COUNT==0: trap goes IDLE → DONE directly; no mem_rd and no out_valid.
- Reset in any state, including mid-READ or with out_valid pending: next cycle is IDLE with all outputs at reset values; the partial word is discarded.
- Throughput with out_ready tied high: one word per 6 cycles (5 READ + 1 EMIT).

Optional Feature:
- Macro: MEM_DUMP_CHECKSUM_EN.
- Defined:
  - A 32-bit sum of every accepted out_data is kept, modulo 2^32, reset to 0.
  - After the last data word, an extra EMIT beat is issued with out_addr=32'hFFFFFFFC and out_data=sum, using the same handshake.
  - DONE is entered only after that beat is accepted.
  - WORD_COUNT==0 still emits one checksum beat with value 0.
- Undefined: no checksum beat and no checksum register.

Test Plan:
- DMEM[8192..8195]=01 02 03 04, WORD_COUNT=1, out_ready=1, trap at cycle 10 → mem_rd at cycles 11–14 with addr 8192..8195; out_valid at cycle 16 with out_addr=8192, out_data=32'h01020304; done=1 at cycle 17.
- WORD_COUNT=10, DMEM words 8192..8228 = 1..10, out_ready=1 → ten beats, addresses 8192+4k, data k+1, spaced 6 cycles apart; done after the tenth.
- Backpressure: out_ready held low for 7 cycles during the first EMIT → out_valid stays high and data stays 32'h00000001 throughout; no further mem_rd until the accept.
- Reset asserted during READ of the third word → IDLE next cycle, all outputs 0; a second trap restarts the dump from 8192.
- Non-trap instructions (32'h44000301), or the trap with instr_valid=0 → no state change; a trap during EMIT does not restart the dump.
- MEM_DUMP_CHECKSUM_EN with words 1..10 → eleventh beat has out_addr=32'hFFFFFFFC and out_data=55; WORD_COUNT=0 → single beat with data 0.
